// File: rtl/tree_router_pkg.sv
// Shared types and routing helpers for the packet routing tree nodes.
package tree_router_pkg;

    localparam int unsigned WIDTH_PACKET_DEF = 28;
    localparam int unsigned WIDTH_ADDR_DEF   = 3;
    localparam int unsigned WIDTH_DEST_DEF   = 3;
    localparam int unsigned NUM_PORTS        = 3;

    typedef enum logic [1:0] {
        PORT_P = 2'd0,
        PORT_L = 2'd1,
        PORT_R = 2'd2
    } port_e;

    // Leaves below a node share the dest bits above LEVEL; the root owns everything.
    function automatic port_e route(input int unsigned dest, input int unsigned dest_w,
                                    input int unsigned level, input int unsigned node_id);
        port_e p;
        if (level < dest_w && (dest >> level) != node_id) begin
            p = PORT_P;
        end else if (((dest >> (level - 1)) & 32'd1) != 32'd0) begin
            p = PORT_R;
        end else begin
            p = PORT_L;
        end
        return p;
    endfunction

    function automatic port_e port_next(input port_e p);
        port_e n;
        case (p)
            PORT_P:  n = PORT_L;
            PORT_L:  n = PORT_R;
            default: n = PORT_P;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/tree_router_node_fifo.sv
// Count-based input FIFO; head is presented directly from storage.
module router_fifo #(
    parameter int unsigned WIDTH      = 34,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_c,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        full_c   = (count_q == CNT_W'(FIFO_DEPTH));
        empty_c  = (count_q == '0);
        do_push  = push && !full_c;
        do_pop   = pop && !empty_c;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only observed while count is nonzero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_c = mem_q[rd_ptr_q];

endmodule

// File: rtl/tree_router_node.sv
// Three-port routing tree node: per-input FIFOs, per-output round-robin and output register.
module tree_router_node
    import tree_router_pkg::*;
#(
    parameter int unsigned WIDTH_packet = WIDTH_PACKET_DEF,
    parameter int unsigned WIDTH_addr   = WIDTH_ADDR_DEF,
    parameter int unsigned WIDTH_dest   = WIDTH_DEST_DEF,
    parameter int unsigned WIDTH        = WIDTH_packet + WIDTH_addr + WIDTH_dest,
    parameter int unsigned LEVEL        = 1,
    parameter int unsigned NODE_ID      = 0,
    parameter int unsigned FIFO_DEPTH   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p_in_valid,
    output logic             p_in_ready,
    input  logic [WIDTH-1:0] p_in_data,
    input  logic             l_in_valid,
    output logic             l_in_ready,
    input  logic [WIDTH-1:0] l_in_data,
    input  logic             r_in_valid,
    output logic             r_in_ready,
    input  logic [WIDTH-1:0] r_in_data,
    output logic             p_out_valid,
    input  logic             p_out_ready,
    output logic [WIDTH-1:0] p_out_data,
    output logic             l_out_valid,
    input  logic             l_out_ready,
    output logic [WIDTH-1:0] l_out_data,
    output logic             r_out_valid,
    input  logic             r_out_ready,
    output logic [WIDTH-1:0] r_out_data,
    output logic             err_uturn
);

    logic [WIDTH-1:0] in_data    [NUM_PORTS];
    logic [WIDTH-1:0] head       [NUM_PORTS];
    logic [WIDTH-1:0] out_data_q [NUM_PORTS];
    logic [WIDTH-1:0] out_data_d [NUM_PORTS];
    port_e            src_route  [NUM_PORTS];
    port_e            ptr_q      [NUM_PORTS];
    port_e            ptr_d      [NUM_PORTS];
    port_e            gnt        [NUM_PORTS];
    port_e            cand;
    logic [NUM_PORTS-1:0] in_valid, out_ready, full, empty, push, pop, discard, found;
    logic [NUM_PORTS-1:0] out_valid_q, out_valid_d;
    logic             err_q, err_d;

    assign in_valid  = {r_in_valid, l_in_valid, p_in_valid};
    assign out_ready = {r_out_ready, l_out_ready, p_out_ready};
    assign in_data[PORT_P] = p_in_data;
    assign in_data[PORT_L] = l_in_data;
    assign in_data[PORT_R] = r_in_data;

    // Acceptance looks only at registered occupancy, never at downstream ready.
    assign push       = in_valid & ~full & {NUM_PORTS{~rst}};
    assign p_in_ready = !full[PORT_P] && !rst;
    assign l_in_ready = !full[PORT_L] && !rst;
    assign r_in_ready = !full[PORT_R] && !rst;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_fifo
        router_fifo #(
            .WIDTH      (WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[g]),
            .push_data (in_data[g]),
            .pop       (pop[g]),
            .head_c    (head[g]),
            .full_c    (full[g]),
            .empty_c   (empty[g])
        );
    end

    always_comb begin
        pop         = '0;
        discard     = '0;
        found       = '0;
        cand        = PORT_P;
        out_valid_d = out_valid_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            src_route[i]  = route(32'(head[i][WIDTH_dest-1:0]), WIDTH_dest, LEVEL, NODE_ID);
            discard[i]    = !empty[i] && (src_route[i] == 2'(i));
            out_data_d[i] = out_data_q[i];
            ptr_d[i]      = ptr_q[i];
            gnt[i]        = PORT_P;
        end
        // U-turn packets leave their FIFO without competing for any output.
        pop   = discard;
        err_d = |discard;

        for (int o = 0; o < NUM_PORTS; o++) begin
            cand = ptr_q[o];
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (!found[o] && !empty[cand] && src_route[cand] == 2'(o) && cand != 2'(o)) begin
                    found[o] = 1'b1;
                    gnt[o]   = cand;
                end
                cand = port_next(cand);
            end
            out_valid_d[o] = out_valid_q[o] && !out_ready[o];
            if ((!out_valid_q[o] || out_ready[o]) && found[o]) begin
                out_valid_d[o] = 1'b1;
                out_data_d[o]  = head[gnt[o]];
                pop[gnt[o]]    = 1'b1;
                ptr_d[o]       = port_next(gnt[o]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                out_data_q[i] <= '0;
                ptr_q[i]      <= PORT_P;
            end
        end else begin
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            for (int i = 0; i < NUM_PORTS; i++) begin
                out_data_q[i] <= out_data_d[i];
                ptr_q[i]      <= ptr_d[i];
            end
        end
    end

    assign p_out_valid = out_valid_q[PORT_P];
    assign l_out_valid = out_valid_q[PORT_L];
    assign r_out_valid = out_valid_q[PORT_R];
    assign p_out_data  = out_data_q[PORT_P];
    assign l_out_data  = out_data_q[PORT_L];
    assign r_out_data  = out_data_q[PORT_R];
    assign err_uturn   = err_q;

endmodule
